// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the RV32I pipeline registers and the hazard controller.
// The pipeline side (master) drives the stage fields, and the controller (slave) drives the stall, flush and forward controls.
interface hazard_ctrl_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        MemReadE, RegWriteM, RegWriteW, PCSrcE, DMemReqM, DMemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MemTimeout;
  logic [31:0] StallCycles, FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output MemReadE, RegWriteM, RegWriteW, PCSrcE, DMemReqM, DMemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
    input  ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  MemReadE, RegWriteM, RegWriteW, PCSrcE, DMemReqM, DMemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
    output ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Five-stage pipeline hazard controller: stall/flush/forward generation, data-memory
// wait sequencing with a sticky timeout, and saturating stall/flush performance counters.
module hazard_ctrl_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t     state;
  logic [7:0] waitCnt;
  logic [8:0] waitInc;
  logic       memWait, loadUse, redirect;

  always_comb begin
    memWait  = hz.DMemReqM & ~hz.DMemReadyM;
    loadUse  = hz.MemReadE & (hz.RdE != 5'd0) &
               ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
    redirect = hz.PCSrcE;
    waitInc  = {1'b0, waitCnt} + 9'd1;
  end

  // Memory wait dominates everything; a taken redirect squashes a pending load-use bubble.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    if (reset) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (memWait) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
    end else if (redirect) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (loadUse) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
      hz.ForwardAE = 2'b01;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
      hz.ForwardBE = 2'b01;
  end

  // Only MEMWAIT cycles that are still waiting advance the timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      waitCnt        <= 8'd0;
      hz.MemTimeout  <= 1'b0;
      hz.StallCycles <= 32'd0;
      hz.FlushCount  <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          waitCnt <= 8'd0;
          if (memWait) state <= MEMWAIT;
        end
        MEMWAIT: begin
          if (!memWait) begin
            state   <= RUN;
            waitCnt <= 8'd0;
          end else begin
            if (waitCnt != 8'hFF) waitCnt <= waitInc[7:0];
            if (32'(waitInc) >= MEM_TIMEOUT) hz.MemTimeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
      if (hz.StallF && hz.StallCycles != 32'hFFFF_FFFF)
        hz.StallCycles <= hz.StallCycles + 32'd1;
      if (hz.FlushE && hz.FlushCount != 32'hFFFF_FFFF)
        hz.FlushCount <= hz.FlushCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboarded bench for hazard_ctrl_unit: the driver pushes reference-model expectations,
// and a negedge monitor pops them and compares them with the DUT.
module tb_hazard_ctrl_unit;
  localparam int unsigned TIMEOUT = 4;

  typedef struct {
    bit       reset;
    bit [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    bit       memReadE, regWriteM, regWriteW, pcSrcE, dmemReq, dmemReady;
  } stim_t;

  typedef struct {
    bit        stallF, stallD, stallE, stallM, flushD, flushE;
    bit [1:0]  fwdA, fwdB;
    bit        regsValid, timeout;
    bit [31:0] stallCycles, flushCount;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  hazard_ctrl_if hif ();

  hazard_ctrl_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .hz(hif));

  always #5 clk = ~clk;

  exp_t      expQ[$];
  int        assertCount = 0;
  int        failCount = 0;
  int        waitRun = 0;
  bit        timeoutFlag = 1'b0;
  bit        regsKnown = 1'b0;
  bit [31:0] stallTotal = 0;
  bit [31:0] flushTotal = 0;

  function automatic bit [1:0] fwdOf(stim_t s, bit [4:0] src);
    if (s.regWriteM && s.rdM != 0 && s.rdM == src) return 2'd2;
    if (s.regWriteW && s.rdW != 0 && s.rdW == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    bit waiting, hazard;
    e = '{default: 0};
    waiting = s.dmemReq && !s.dmemReady;
    hazard = s.memReadE && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
    if (s.reset) {e.flushD, e.flushE} = 2'b11;
    else if (waiting) {e.stallF, e.stallD, e.stallE, e.stallM} = 4'hF;
    else if (s.pcSrcE) {e.flushD, e.flushE} = 2'b11;
    else if (hazard) {e.stallF, e.stallD, e.flushE} = 3'b111;
    e.fwdA = fwdOf(s, s.rs1E);
    e.fwdB = fwdOf(s, s.rs2E);
    e.regsValid = regsKnown;
    e.timeout = timeoutFlag;
    e.stallCycles = stallTotal;
    e.flushCount = flushTotal;
    return e;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus: drive, predict, then advance the model across the edge.
  task automatic applyStimulus(stim_t s);
    exp_t e;
    reset = s.reset;
    hif.Rs1D = s.rs1D; hif.Rs2D = s.rs2D; hif.Rs1E = s.rs1E; hif.Rs2E = s.rs2E;
    hif.RdE = s.rdE; hif.RdM = s.rdM; hif.RdW = s.rdW;
    hif.MemReadE = s.memReadE; hif.RegWriteM = s.regWriteM; hif.RegWriteW = s.regWriteW;
    hif.PCSrcE = s.pcSrcE; hif.DMemReqM = s.dmemReq; hif.DMemReadyM = s.dmemReady;
    e = predict(s);
    expQ.push_back(e);
    @(posedge clk);
    if (s.reset) begin
      waitRun = 0; timeoutFlag = 0; stallTotal = 0; flushTotal = 0; regsKnown = 1;
    end else begin
      waitRun = (s.dmemReq && !s.dmemReady) ? waitRun + 1 : 0;
      if (waitRun >= int'(TIMEOUT) + 1) timeoutFlag = 1;
      if (e.stallF && stallTotal != 32'hFFFF_FFFF) stallTotal++;
      if (e.flushE && flushTotal != 32'hFFFF_FFFF) flushTotal++;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("StallF", 32'(hif.StallF), 32'(e.stallF));
      checkOutput("StallD", 32'(hif.StallD), 32'(e.stallD));
      checkOutput("StallE", 32'(hif.StallE), 32'(e.stallE));
      checkOutput("StallM", 32'(hif.StallM), 32'(e.stallM));
      checkOutput("FlushD", 32'(hif.FlushD), 32'(e.flushD));
      checkOutput("FlushE", 32'(hif.FlushE), 32'(e.flushE));
      checkOutput("ForwardAE", 32'(hif.ForwardAE), 32'(e.fwdA));
      checkOutput("ForwardBE", 32'(hif.ForwardBE), 32'(e.fwdB));
      if (e.regsValid) begin
        checkOutput("MemTimeout", 32'(hif.MemTimeout), 32'(e.timeout));
        checkOutput("StallCycles", hif.StallCycles, e.stallCycles);
        checkOutput("FlushCount", hif.FlushCount, e.flushCount);
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t randomStim();
    stim_t s;
    s.reset = ($urandom_range(0, 63) == 0);
    s.rs1D = 5'($urandom_range(0, 3)); s.rs2D = 5'($urandom_range(0, 3));
    s.rs1E = 5'($urandom_range(0, 3)); s.rs2E = 5'($urandom_range(0, 3));
    s.rdE = 5'($urandom_range(0, 3)); s.rdM = 5'($urandom_range(0, 3));
    s.rdW = 5'($urandom_range(0, 3));
    s.memReadE = 1'($urandom_range(0, 1)); s.regWriteM = 1'($urandom_range(0, 1));
    s.regWriteW = 1'($urandom_range(0, 1)); s.pcSrcE = ($urandom_range(0, 5) == 0);
    s.dmemReq = ($urandom_range(0, 2) == 0); s.dmemReady = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    stim_t s;
    int drain;
    s = idle();
    s.reset = 1;
    @(posedge clk); #1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idle());

    s = idle(); s.memReadE = 1; s.rdE = 5; s.rs1D = 5;
    applyStimulus(s);
    applyStimulus(idle());

    s = idle(); s.rs1E = 7; s.rdM = 7; s.rdW = 7; s.regWriteM = 1; s.regWriteW = 1;
    applyStimulus(s);
    s.regWriteM = 0;
    applyStimulus(s);
    s.rdW = 0;
    applyStimulus(s);

    s = idle(); s.memReadE = 1; s.rdE = 3; s.rs2D = 3; s.pcSrcE = 1;
    applyStimulus(s);

    s = idle(); s.dmemReq = 1;
    repeat (3) applyStimulus(s);
    s.dmemReady = 1;
    applyStimulus(s);
    applyStimulus(idle());

    s = idle(); s.dmemReq = 1;
    repeat (6) applyStimulus(s);
    s.dmemReady = 1;
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    s = idle(); s.dmemReq = 1;
    repeat (2) applyStimulus(s);
    s.reset = 1;
    applyStimulus(s);
    applyStimulus(idle());

    for (int i = 0; i < 400; i++) applyStimulus(randomStim());

    drain = 0;
    while (expQ.size() > 0 && drain < 5) begin
      @(negedge clk);
      drain++;
    end
    if (expQ.size() > 0) checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
